serial_loader: RTL and testbench

SERIAL_LOADER -- requirements
Module: serial_loader

---
 rtl/loader_pkg.sv | 24 ++
 rtl/shift_deser.sv | 74 +++++++
 rtl/serial_loader.sv | 167 ++++++++++++++++
 tb/tb_serial_loader.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared constants for the serial bank loader: mode field layout, opcodes, FSM states.
// SERIAL_LOADER_PARITY_EN adds one even-parity bit after every word.
package loader_pkg;

  localparam int MODE_OP_LSB   = 0;
  localparam int MODE_OP_MSB   = 3;
  localparam int MODE_BANK_LSB = 4;
  localparam int MODE_BANK_MSB = 7;

  localparam logic [3:0] OP_LOAD = 4'h2;

`ifdef SERIAL_LOADER_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_deser.sv
// MSB-first deserialiser: bit counter, shift register and optional parity check.
// SERIAL_LOADER_PARITY_EN appends one even-parity bit per word.
module shift_deser
  import loader_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              sample,
  input  logic              abort,
  input  logic              in_bit,
  output logic              word_done,
  output logic              par_ok,
  output logic [WORD_W-1:0] word
);

  localparam int BITS  = WORD_W + PAR_BITS;
  localparam int CNT_W = $clog2(BITS + 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_base;
  logic [WORD_W-1:0] sr_q, sr_d, sr_base, sr_next;

  always_comb begin
    cnt_base  = start ? '0 : cnt_q;
    sr_base   = start ? '0 : sr_q;
    sr_next   = {sr_base[WORD_W-2:0], in_bit};
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    word_done = 1'b0;
    par_ok    = 1'b1;
    word      = '0;
    if (abort) begin
      cnt_d = '0;
      sr_d  = '0;
    end else if (start || sample) begin
`ifdef SERIAL_LOADER_PARITY_EN
      // Data bits are already in sr_base when the parity bit arrives.
      if (cnt_base == CNT_W'(WORD_W)) begin
        word_done = 1'b1;
        word      = sr_base;
        par_ok    = ~(^{sr_base, in_bit});
        cnt_d     = '0;
        sr_d      = '0;
      end else begin
        sr_d  = sr_next;
        cnt_d = cnt_base + 1'b1;
      end
`else
      if (cnt_base == CNT_W'(WORD_W - 1)) begin
        word_done = 1'b1;
        word      = sr_next;
        cnt_d     = '0;
        sr_d      = '0;
      end else begin
        sr_d  = sr_next;
        cnt_d = cnt_base + 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      sr_q  <= sr_d;
    end
  end

endmodule

// File: rtl/serial_loader.sv
// Serial bank loader: assembles MSB-first words and writes them to consecutive bank addresses.
// SERIAL_LOADER_PARITY_EN enables per-word even parity with sticky err on mismatch.
//
// state | meaning
// IDLE  | waiting for opcode LOAD with a valid bank index
// SHIFT | sampling bits, writing each completed word
// FULL  | last address written; waits for opcode to leave LOAD
module serial_loader
  import loader_pkg::*;
#(
  parameter int  WORD_W    = 8,
  parameter int  DEPTH     = 64,
  parameter int  NUM_BANKS = 4,
  localparam int ADDR_W    = $clog2(DEPTH),
  localparam int BANK_W    = $clog2(NUM_BANKS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [31:0]       mode,
  input  logic              in_bit,
  output logic              wr_en,
  output logic [BANK_W-1:0] wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t              state_q, state_d;
  logic [BANK_W-1:0]   bank_q, bank_d, bank_new;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wr_en_q, wr_en_d;
  logic [BANK_W-1:0]   wr_bank_q, wr_bank_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0]   wr_data_q, wr_data_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [3:0]          opcode, bank_idx;
  logic                is_load, bank_ok;
  logic                ds_start, ds_sample, ds_abort;
  logic                ds_word_done, ds_par_ok;
  logic [WORD_W-1:0]   ds_word;
  logic                unused_mode;

  assign opcode      = mode[MODE_OP_MSB:MODE_OP_LSB];
  assign bank_idx    = mode[MODE_BANK_MSB:MODE_BANK_LSB];
  assign unused_mode = ^mode[31:8];
  assign is_load     = (opcode == OP_LOAD);
  assign bank_ok     = (int'({28'd0, bank_idx}) < NUM_BANKS);
  assign bank_new    = BANK_W'(bank_idx);

  // A bank switch mid-load restarts assembly with this cycle's bit as the first bit.
  assign ds_start  = enable && is_load && bank_ok &&
                     ((state_q == IDLE) || ((state_q == SHIFT) && (bank_new != bank_q)));
  assign ds_sample = enable && is_load && bank_ok && (state_q == SHIFT) && (bank_new == bank_q);
  assign ds_abort  = enable && (state_q == SHIFT) && (!is_load || !bank_ok);

  shift_deser #(.WORD_W(WORD_W)) u_deser (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (ds_start),
    .sample    (ds_sample),
    .abort     (ds_abort),
    .in_bit    (in_bit),
    .word_done (ds_word_done),
    .par_ok    (ds_par_ok),
    .word      (ds_word)
  );

  always_comb begin
    state_d   = state_q;
    bank_d    = bank_q;
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    done_d    = 1'b0;
    wr_bank_d = wr_bank_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = err_q;
    if (enable) begin
      unique case (state_q)
        IDLE: begin
          if (is_load) begin
            if (!bank_ok) begin
              err_d = 1'b1;
            end else begin
              state_d = SHIFT;
              bank_d  = bank_new;
              addr_d  = '0;
`ifdef SERIAL_LOADER_PARITY_EN
              err_d   = 1'b0;
`endif
            end
          end
        end
        SHIFT: begin
          if (!is_load) begin
            state_d = IDLE;
          end else if (!bank_ok) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (bank_new != bank_q) begin
            bank_d = bank_new;
            addr_d = '0;
          end
        end
        FULL: begin
          if (!is_load) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    // Address stops at DEPTH-1; FULL prevents any further write into the bank.
    if (ds_word_done) begin
      if (ds_par_ok) begin
        wr_en_d   = 1'b1;
        wr_data_d = ds_word;
        wr_bank_d = bank_d;
        wr_addr_d = addr_d;
        if (addr_d == ADDR_W'(DEPTH - 1)) begin
          done_d  = 1'b1;
          state_d = FULL;
        end else begin
          addr_d = addr_d + 1'b1;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      bank_q    <= '0;
      addr_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_bank_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bank_q    <= bank_d;
      addr_q    <= addr_d;
      wr_en_q   <= wr_en_d;
      wr_bank_q <= wr_bank_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_bank = wr_bank_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign done    = done_q;
  assign err     = err_q;
  assign busy    = (state_q == SHIFT);

endmodule

// File: tb/tb_serial_loader.sv
// Directed bench for serial_loader (WORD_W=8, DEPTH=4, NUM_BANKS=4) with a word-level reference model.
// Follows SERIAL_LOADER_PARITY_EN when defined.
module tb_serial_loader;

  localparam int WORD_W    = 8;
  localparam int DEPTH     = 4;
  localparam int NUM_BANKS = 4;
`ifdef SERIAL_LOADER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] mode = 32'h0;
  logic        in_bit = 1'b0;
  logic        wr_en;
  logic [1:0]  wr_bank;
  logic [1:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        busy, done, err;

  int n_total = 0;
  int n_pass  = 0;
  bit started = 0;

  always #5 clk = ~clk;

  serial_loader #(.WORD_W(WORD_W), .DEPTH(DEPTH), .NUM_BANKS(NUM_BANKS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .mode    (mode),
    .in_bit  (in_bit),
    .wr_en   (wr_en),
    .wr_bank (wr_bank),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Word-level model: phase 0 = waiting, 1 = loading, 2 = bank full.
  int m_phase, m_bank, m_addr, m_nbits, m_acc;
  int m_data, m_wbank, m_waddr;
  bit m_wr_en, m_done, m_err;

  task automatic model_take(input bit b);
    bit ok;
    m_acc = m_acc * 2 + int'(b);
    m_nbits++;
    if (m_nbits == WORD_W + PAR) begin
      ok = (PAR == 0) || (($countones(m_acc) % 2) == 0);
      if (ok) begin
        m_wr_en = 1;
        m_data  = (m_acc >> PAR) & 255;
        m_wbank = m_bank;
        m_waddr = m_addr;
        if (m_addr == DEPTH - 1) begin
          m_done  = 1;
          m_phase = 2;
        end else begin
          m_addr++;
        end
      end else begin
        m_err = 1;
      end
      m_nbits = 0;
      m_acc   = 0;
    end
  endtask

  task automatic model_begin(input int bk, input bit b);
    m_bank  = bk;
    m_addr  = 0;
    m_nbits = 0;
    m_acc   = 0;
    model_take(b);
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = 0; m_bank = 0; m_addr = 0; m_nbits = 0; m_acc = 0;
      m_data = 0; m_wbank = 0; m_waddr = 0;
      m_wr_en = 0; m_done = 0; m_err = 0;
    end else begin
      int  op, bk;
      bit  load;
      m_wr_en = 0;
      m_done  = 0;
      op   = int'(mode[3:0]);
      bk   = int'(mode[7:4]);
      load = (op == 2);
      if (enable) begin
        if (m_phase == 0) begin
          if (load) begin
            if (bk >= NUM_BANKS) m_err = 1;
            else begin
              m_phase = 1;
              if (PAR == 1) m_err = 0;
              model_begin(bk, in_bit);
            end
          end
        end else if (m_phase == 1) begin
          if (!load) m_phase = 0;
          else if (bk >= NUM_BANKS) begin
            m_err   = 1;
            m_phase = 0;
          end else if (bk != m_bank) model_begin(bk, in_bit);
          else model_take(in_bit);
        end else begin
          if (!load) m_phase = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("cmp_wr_en", {31'd0, wr_en}, {31'd0, m_wr_en});
      check("cmp_done",  {31'd0, done},  {31'd0, m_done});
      check("cmp_busy",  {31'd0, busy},  {31'd0, (m_phase == 1) && reset_n});
      check("cmp_err",   {31'd0, err},   {31'd0, m_err});
      if (m_wr_en || !reset_n) begin
        check("cmp_wr_data", {24'd0, wr_data}, m_data);
        check("cmp_wr_bank", {30'd0, wr_bank}, m_wbank);
        check("cmp_wr_addr", {30'd0, wr_addr}, m_waddr);
      end
    end
  end

  task automatic drive(input logic en, input logic [31:0] md, input logic b);
    @(posedge clk);
    #2;
    enable = en;
    mode   = md;
    in_bit = b;
  endtask

  task automatic send_word(input logic [31:0] md, input logic [7:0] w, input logic bad_par);
    for (int i = 7; i >= 0; i--) drive(1'b1, md, w[i]);
    if (PAR == 1) drive(1'b1, md, (^w) ^ bad_par);
  endtask

  initial begin
    int seen;
    logic [7:0] stall_w;

    #1 reset_n = 1'b0;
    started = 1;
    repeat (3) @(negedge clk);
    check("rst_wr_en",   {31'd0, wr_en},   0);
    check("rst_wr_bank", {30'd0, wr_bank}, 0);
    check("rst_wr_addr", {30'd0, wr_addr}, 0);
    check("rst_wr_data", {24'd0, wr_data}, 0);
    check("rst_busy",    {31'd0, busy},    0);
    check("rst_done",    {31'd0, done},    0);
    check("rst_err",     {31'd0, err},     0);
    @(posedge clk); #2 reset_n = 1'b1;
    drive(1'b1, 32'h0, 1'b0);

    // single word 0xB2 to bank 1
    send_word(32'h0000_0012, 8'hB2, 1'b0);
    drive(1'b1, 32'h0, 1'b0);
    @(negedge clk);
    check("single_wr_en",   {31'd0, wr_en},   1);
    check("single_wr_data", {24'd0, wr_data}, 32'hB2);
    check("single_wr_bank", {30'd0, wr_bank}, 1);
    check("single_wr_addr", {30'd0, wr_addr}, 0);

    // fill a whole bank
    for (int w = 1; w <= 4; w++) send_word(32'h0000_0012, 8'(w), 1'b0);
    drive(1'b1, 32'h0000_0012, 1'b1);
    @(negedge clk);
    check("full_wr_en",   {31'd0, wr_en},   1);
    check("full_done",    {31'd0, done},    1);
    check("full_wr_addr", {30'd0, wr_addr}, 3);
    check("full_wr_data", {24'd0, wr_data}, 4);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h0000_0012, 1'(i & 1));
      @(negedge clk);
      seen += int'(wr_en) + int'(busy);
    end
    check("full_quiet", seen, 0);
    drive(1'b1, 32'h0, 1'b0);

    // abort after 5 bits, then reload
    drive(1'b1, 32'h0000_0012, 1'b1);
    drive(1'b1, 32'h0000_0012, 1'b0);
    drive(1'b1, 32'h0000_0012, 1'b1);
    drive(1'b1, 32'h0000_0012, 1'b1);
    drive(1'b1, 32'h0000_0012, 1'b0);
    drive(1'b1, 32'h0, 1'b0);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      seen += int'(wr_en);
    end
    check("abort_no_wr", seen, 0);
    send_word(32'h0000_0012, 8'h5A, 1'b0);
    drive(1'b1, 32'h0, 1'b0);
    @(negedge clk);
    check("abort_re_wr_en",   {31'd0, wr_en},   1);
    check("abort_re_wr_addr", {30'd0, wr_addr}, 0);
    check("abort_re_wr_data", {24'd0, wr_data}, 32'h5A);

    // stall 3 cycles after bit 4 of 0xB2
    stall_w = 8'hB2;
    for (int i = 7; i >= 4; i--) drive(1'b1, 32'h0000_0012, stall_w[i]);
    repeat (3) drive(1'b0, 32'h0000_0012, 1'b1);
    for (int i = 3; i >= 0; i--) drive(1'b1, 32'h0000_0012, stall_w[i]);
    if (PAR == 1) drive(1'b1, 32'h0000_0012, ^stall_w);
    @(negedge clk);
    check("stall_pre_wr_en", {31'd0, wr_en}, 0);
    drive(1'b1, 32'h0, 1'b0);
    @(negedge clk);
    check("stall_wr_en",   {31'd0, wr_en},   1);
    check("stall_wr_data", {24'd0, wr_data}, 32'hB2);

    // bank change mid-word restarts on the new bank; upper mode bits ignored
    drive(1'b1, 32'h0000_0012, 1'b1);
    drive(1'b1, 32'h0000_0012, 1'b1);
    drive(1'b1, 32'h0000_0012, 1'b0);
    send_word(32'h1234_5622, 8'hC3, 1'b0);
    drive(1'b1, 32'h0, 1'b0);
    @(negedge clk);
    check("bank_chg_wr_en",   {31'd0, wr_en},   1);
    check("bank_chg_wr_bank", {30'd0, wr_bank}, 2);
    check("bank_chg_wr_addr", {30'd0, wr_addr}, 0);
    check("bank_chg_wr_data", {24'd0, wr_data}, 32'hC3);

    // reset mid-word loses the partial word
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h0000_0012, 1'b1);
    @(posedge clk); #2;
    reset_n = 1'b0;
    mode    = 32'h0;
    @(negedge clk);
    check("rst_mid_busy",  {31'd0, busy},  0);
    check("rst_mid_wr_en", {31'd0, wr_en}, 0);
    @(posedge clk); #2 reset_n = 1'b1;
    repeat (3) drive(1'b1, 32'h0, 1'b1);

`ifdef SERIAL_LOADER_PARITY_EN
    send_word(32'h0000_0012, 8'hB2, 1'b1);
    drive(1'b1, 32'h0, 1'b0);
    @(negedge clk);
    check("par_bad_err",   {31'd0, err},   1);
    check("par_bad_wr_en", {31'd0, wr_en}, 0);
    send_word(32'h0000_0012, 8'hB2, 1'b0);
    drive(1'b1, 32'h0, 1'b0);
    @(negedge clk);
    check("par_ok_wr_en",   {31'd0, wr_en},   1);
    check("par_ok_wr_addr", {30'd0, wr_addr}, 0);
    check("par_ok_err",     {31'd0, err},     0);
`endif

    // out-of-range bank index
    drive(1'b1, 32'h0000_0052, 1'b1);
    drive(1'b1, 32'h0000_0052, 1'b1);
    @(negedge clk);
    check("bad_bank_err",  {31'd0, err},  1);
    check("bad_bank_busy", {31'd0, busy}, 0);
    repeat (3) drive(1'b1, 32'h0, 1'b0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
